// File: rtl/lab01_vector_gen.sv
// lab01_vector_gen: walks a 4-bit stimulus vector 0..15 into a downstream
// NOR/NAND/AND stage, holding each vector for DWELL cycles, and optionally
// checks the stage response Y against the ideal function.
//
// Build option: define LAB01_VGEN_CHECK_EN to include the response checker
// (ERR_CNT / PASS). Without it, Y is ignored and ERR_CNT / PASS read 0;
// sequencing, BUSY and DONE timing are identical in both builds.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start_i; stimulus outputs held at 0
// ST_DRIVE  | presenting vector idx_q, DWELL cycles per vector
// ST_FINISH | one-cycle DONE pulse, PASS latched, then back to IDLE

`timescale 1ns/1ps

module lab01_vector_gen #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       y_i,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  output logic       d_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [4:0] err_cnt_o,
  output logic       pass_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [4:0] ERR_MAX    = 5'd16;

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] dwell_q, dwell_d;
  logic       last_dwell;

  // The vector index register is the stimulus itself: it is forced to 0
  // whenever the FSM leaves DRIVE, so the outputs read 0 in IDLE.
  assign a_o    = idx_q[3];
  assign b_o    = idx_q[2];
  assign c_o    = idx_q[1];
  assign d_o    = idx_q[0];
  assign busy_o = (state_q == ST_DRIVE);
  assign done_o = (state_q == ST_FINISH);

  assign last_dwell = (dwell_q == DWELL_LAST);

  // State, vector index and dwell counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      dwell_q <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
    end
  end

  // Next-state sequencing: abort beats the end-of-dwell step.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_DRIVE;
          idx_d   = 4'd0;
          dwell_d = 8'd0;
        end
      end
      ST_DRIVE: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          idx_d   = 4'd0;
          dwell_d = 8'd0;
        end else if (last_dwell) begin
          dwell_d = 8'd0;
          if (idx_q == 4'd15) begin
            state_d = ST_FINISH;
            idx_d   = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 4'd0;
        dwell_d = 8'd0;
      end
    endcase
  end

`ifdef LAB01_VGEN_CHECK_EN

  logic [4:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       y_expected;

  // Ideal downstream response: NOR(A,B) AND NAND(C,D), from the registered vector.
  assign y_expected = ~(a_o | b_o) & ~(c_o & d_o);

  assign err_cnt_o = err_q;
  assign pass_o    = pass_q;

  // Mismatch counter and pass flag registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q  <= 5'd0;
      pass_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      pass_q <= pass_d;
    end
  end

  // Compare on the last dwell cycle of each vector; abort discards that compare.
  always_comb begin
    err_d  = err_q;
    pass_d = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          err_d  = 5'd0;
          pass_d = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (abort_i) begin
          pass_d = 1'b0;
        end else if (last_dwell && (y_i != y_expected) && (err_q != ERR_MAX)) begin
          err_d = err_q + 5'd1;
        end
      end
      ST_FINISH: begin
        pass_d = (err_q == 5'd0);
      end
      default: begin
        err_d  = 5'd0;
        pass_d = 1'b0;
      end
    endcase
  end

`else

  logic unused_y;

  assign unused_y  = y_i;
  assign err_cnt_o = 5'd0;
  assign pass_o    = 1'b0;

`endif

endmodule

// File: tb/tb_lab01_vector_gen.sv
// tb_lab01_vector_gen: randomized self-checking bench for lab01_vector_gen.
// The reference model works per run in terms of "cycle k of the run shows
// vector k/DWELL" and "the ideal response is 1 only for vectors 0,1,2".
// Define LAB01_VGEN_CHECK_EN for both files to exercise the checker build.

`timescale 1ns/1ps

module tb_lab01_vector_gen;

  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       y = 1'b0;
  logic       a, b, c, d;
  logic       busy, done, pass;
  logic [4:0] err_cnt;
  logic [3:0] vec;

  int n_checks = 0;
  int n_fail   = 0;
  int model_err = 0;
  bit model_pass = 1'b0;

  lab01_vector_gen #(.DWELL(DW)) u_dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .start_i   (start),
    .abort_i   (abort),
    .y_i       (y),
    .a_o       (a),
    .b_o       (b),
    .c_o       (c),
    .d_o       (d),
    .busy_o    (busy),
    .done_o    (done),
    .err_cnt_o (err_cnt),
    .pass_o    (pass)
  );

  assign vec = {a, b, c, d};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Ideal stage response: NOR of the top pair is 1 only below 4, NAND of the
  // bottom pair is 0 only when both low bits are set.
  function automatic bit golden(input int v);
    return (v < 4) && ((v % 4) != 3);
  endfunction

  function automatic int exp_err();
`ifdef LAB01_VGEN_CHECK_EN
    return model_err;
`else
    return 0;
`endif
  endfunction

  function automatic bit exp_pass();
`ifdef LAB01_VGEN_CHECK_EN
    return model_pass;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_vec"},  vec, 0);
    chk({tag, "_err"},  err_cnt, exp_err());
    chk({tag, "_pass"}, pass, exp_pass());
  endtask

  // One run. ymode: 0 ideal, 1 stuck 0, 2 inverted, 3 random.
  // abort_at: run cycle in which ABORT is raised, -1 for none.
  task automatic run(input int ymode, input int abort_at, input bit noisy_start);
    int  v;
    bit  last;
    start = 1'b1;
    tick();
    start = 1'b0;
    model_err  = 0;
    model_pass = 1'b0;
    for (int k = 0; k < 16 * DW; k++) begin
      v    = k / DW;
      last = ((k % DW) == DW - 1);
      chk("drv_busy", busy, 1);
      chk("drv_vec",  vec, v);
      chk("drv_done", done, 0);
      chk("drv_err",  err_cnt, exp_err());
      case (ymode)
        0:       y = golden(v);
        1:       y = 1'b0;
        2:       y = !golden(v);
        default: y = 1'($urandom_range(0, 1));
      endcase
      start = noisy_start ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        model_pass = 1'b0;
        chk_idle("abort");
        tick();
        chk_idle("abort_hold");
        return;
      end
      if (last && (y != golden(v)) && (model_err < 16))
        model_err++;
      tick();
    end
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 0);
    chk("fin_err",  err_cnt, exp_err());
    start = 1'b1;
    tick();
    start = 1'b0;
    model_pass = (model_err == 0);
    chk_idle("post_run");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("idle_hold");
    end
  endtask

  initial begin
    #12;
    chk_idle("reset");
    rst_n = 1'b1;
    tick();
    tick();
    chk_idle("after_reset");

    run(0, -1, 1'b0);
    run(1, -1, 1'b0);
`ifdef LAB01_VGEN_CHECK_EN
    chk("stuck0_count", err_cnt, 3);
`endif
    run(2, -1, 1'b0);
`ifdef LAB01_VGEN_CHECK_EN
    chk("inverse_sat", err_cnt, 16);
`endif
    run(0, 5 * DW + 1, 1'b0);
    run(0, -1, 1'b0);
    run(2, 3 * DW + DW - 1, 1'b0);
`ifdef LAB01_VGEN_CHECK_EN
    chk("abort_discard", err_cnt, 3);
`endif

    for (int r = 0; r < 8; r++) begin
      int ab;
      ab = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 16 * DW - 1));
      run(int'($urandom_range(0, 3)), ab, 1'b1);
    end

    // Asynchronous reset in the middle of vector 9.
    start = 1'b1;
    tick();
    start = 1'b0;
    y = 1'b0;
    for (int k = 0; k < 9 * DW + 1; k++) tick();
    chk("pre_rst_vec", vec, 9);
    #2;
    rst_n = 1'b0;
    #1;
    model_err  = 0;
    model_pass = 1'b0;
    chk_idle("async_rst");
    tick();
    chk_idle("rst_held");
    #3;
    rst_n = 1'b1;
    run(0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
